// File: rtl/apb_reg_pkg.sv
// Purpose: shared types, limits and helpers for the APB register completer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_reg_pkg;

    // Transfer sequencing states of the completer.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } apb_state_e;

    // Largest supported number of wait cycles per access phase.
    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

    // pprot bit positions.
    localparam int PPROT_PRIV_BIT    = 0;
    localparam int PPROT_NSECURE_BIT = 1;
    localparam int PPROT_INSTR_BIT   = 2;

    // Number of byte-offset address bits below the register index.
    function automatic int calc_ofs(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Purpose: register array with byte-strobe writes, indexed read mux and flat export.
// Latency: write visible on reg_q/rd_dat the cycle after wr_en; read mux is combinational.
// Backpressure: none; a write is committed whenever wr_en is high.
module apb_reg_bank #(
    parameter int                NUM_REGS  = 8,
    parameter int                DATA_W    = 32,
    parameter int                IDX_W     = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_dat,
    input  logic [DATA_W/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_dat,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int NUM_LANES = DATA_W / 8;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Byte-lane write of the addressed register; unstrobed lanes keep their value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < NUM_LANES; b++) begin
                        if (wr_strb[b]) begin
                            regs[i][b*8 +: 8] <= wr_dat[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux; an index with no backing register returns zero.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_dat = regs[i];
            end
        end
    end

    // Flatten the array so register i sits at [i*DATA_W +: DATA_W].
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: rtl/apb_reg_slave.sv
// Purpose: parametrised APB4 completer over a register bank (optional privilege check: APB_REG_PROT_EN).
// Latency: WAIT_STATES access cycles with pready low, then one pready cycle; all outputs registered.
// Backpressure: pready held low for WAIT_STATES cycles; psel drop aborts, penable drop restarts setup.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter logic [255:0]      PRIV_MASK   = '0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    input  logic [2:0]                 pprot,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int                  OFS       = calc_ofs(DATA_W);
    localparam int                  IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0]   LANE_MASK = ADDR_W'((1 << OFS) - 1);
    localparam logic [ADDR_W-1:0]   REGS_LIM  = ADDR_W'(NUM_REGS);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    pready_d, pslverr_d;
    logic [DATA_W-1:0]       prdata_d;

    logic                    cap_write;
    logic [IDX_W-1:0]        cap_idx;
    logic [DATA_W-1:0]       cap_wdata;
    logic [DATA_W/8-1:0]     cap_strb;
    logic                    cap_err;

    logic                    setup;
    logic                    cap_en;
    logic                    wr_en;
    logic                    resp_now;
    logic [ADDR_W-1:0]       dec_idx_full;
    logic [IDX_W-1:0]        dec_idx;
    logic                    new_err;
    logic                    cap_err_eff;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_W-1:0]       rd_dat;
    logic                    resp_err;
    logic                    resp_write;
    logic [DATA_W-1:0]       resp_rdata;
    logic                    unused_cfg;

    assign setup        = psel && !penable;
    assign dec_idx_full = paddr >> OFS;
    assign dec_idx      = dec_idx_full[IDX_W-1:0];

`ifdef APB_REG_PROT_EN
    logic cap_priv;

    // A privileged register touched by an unprivileged access is an error.
    function automatic logic prot_err(input logic [IDX_W-1:0] idx, input logic priv);
        return PRIV_MASK[idx] && !priv;
    endfunction

    assign new_err     = ((paddr & LANE_MASK) != '0) || (dec_idx_full >= REGS_LIM)
                         || prot_err(dec_idx, pprot[PPROT_PRIV_BIT]);
    assign cap_err_eff = cap_err || prot_err(cap_idx, cap_priv);

    // Privilege attribute captured with the setup phase.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cap_priv <= 1'b0;
        end else if (cap_en) begin
            cap_priv <= pprot[PPROT_PRIV_BIT];
        end
    end
`else
    assign new_err     = ((paddr & LANE_MASK) != '0) || (dec_idx_full >= REGS_LIM);
    assign cap_err_eff = cap_err;
`endif

    // pprot and the privilege mask only matter when the privilege check is built in.
    assign unused_cfg = ^{pprot[PPROT_INSTR_BIT], pprot[PPROT_NSECURE_BIT],
                          pprot[PPROT_PRIV_BIT], PRIV_MASK};

    // A response raised on a setup edge (zero wait states) uses the live decode;
    // otherwise it uses what was captured at setup.
    assign rd_idx     = setup ? dec_idx : cap_idx;
    assign resp_err   = setup ? new_err : cap_err_eff;
    assign resp_write = setup ? pwrite  : cap_write;
    assign resp_rdata = (!resp_write && !resp_err) ? rd_dat : '0;

    // Next-state, wait counter, response outputs and bank write strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        cap_en    = 1'b0;
        wr_en     = 1'b0;
        resp_now  = 1'b0;

        if (setup) begin
            // Setup phase in any state starts (or restarts) a transfer.
            state_d   = ACCESS;
            cap_en    = 1'b1;
            cnt_d     = WS_LOAD;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            resp_now  = (WAIT_STATES == 0);
        end else begin
            case (state_q)
                ACCESS: begin
                    if (!psel) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else if (pready) begin
                        wr_en     = cap_write && !cap_err_eff;
                        state_d   = COMPLETE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else begin
                        cnt_d    = cnt_q - WAIT_CNT_W'(1);
                        resp_now = (cnt_q == WAIT_CNT_W'(1));
                    end
                end
                COMPLETE: begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (resp_now) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_rdata;
        end
    end

    // FSM state, wait counter and registered APB response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    // Transfer attributes captured in the setup phase.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            cap_err   <= 1'b0;
        end else if (cap_en) begin
            cap_write <= pwrite;
            cap_idx   <= dec_idx;
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
            cap_err   <= ((paddr & LANE_MASK) != '0) || (dec_idx_full >= REGS_LIM);
        end
    end

    apb_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .pclk    (pclk),
        .presetn (presetn),
        .wr_en   (wr_en),
        .wr_idx  (cap_idx),
        .wr_dat  (cap_wdata),
        .wr_strb (cap_strb),
        .rd_idx  (rd_idx),
        .rd_dat  (rd_dat),
        .reg_q   (reg_q)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Purpose: directed self-checking bench for apb_reg_slave (zero-wait and 3-wait instances).
// Latency: checks pready timing, read data, errors, byte strobes, abort and async reset.
// Backpressure: every wait on pready is bounded; an expired bound counts as a failure.
module tb_apb_reg_slave;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic         psel_a = 1'b0;
    logic         psel_b = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [2:0]   pprot = '0;

    logic [31:0]  prdata_a, prdata_b;
    logic         pready_a, pready_b;
    logic         pslverr_a, pslverr_b;
    logic [255:0] reg_q_a, reg_q_b;

    logic         cur_b = 1'b0;
    logic         cur_rdy, cur_err;
    logic [31:0]  cur_rdata;

    int n_chk = 0;
    int n_bad = 0;

    logic [255:0] exp_a;
    logic [255:0] exp_b;
    logic [31:0]  rdat;
    logic         err;
    int           nw;

    always #5 pclk = ~pclk;

    apb_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0),
        .RESET_VAL(32'h0000_0000), .PRIV_MASK(256'h1)
    ) dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .reg_q(reg_q_a)
    );

    apb_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3),
        .RESET_VAL(32'hA5A5_0000), .PRIV_MASK(256'h0)
    ) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .reg_q(reg_q_b)
    );

    assign cur_rdy   = cur_b ? pready_b  : pready_a;
    assign cur_err   = cur_b ? pslverr_b : pslverr_a;
    assign cur_rdata = cur_b ? prdata_b  : prdata_a;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One APB transfer, entered and left on a falling edge. With b2b set, psel
    // stays high so the caller can issue the next setup in the COMPLETE cycle.
    task automatic apb_xfer(input bit which, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input bit b2b,
                            output logic [31:0] rd, output logic er, output int waits);
        cur_b   = which;
        psel_a  = !which;
        psel_b  = which;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        while (!cur_rdy && waits < 32) begin
            waits++;
            @(negedge pclk);
        end
        if (!cur_rdy) check("pready_timeout", 1, 0);
        rd = cur_rdata;
        er = cur_err;
        @(negedge pclk);
        check("complete_pready_low", cur_rdy, 0);
        if (!b2b) begin
            psel_a  = 1'b0;
            psel_b  = 1'b0;
            penable = 1'b0;
            @(negedge pclk);
        end
    endtask

    initial begin
        exp_a = '0;
        exp_b = {8{32'hA5A5_0000}};

        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_pready", pready_a, 0);
        check("rst_pslverr", pslverr_a, 0);
        check("rst_prdata", prdata_a, 0);
        check("rst_reg_q_a", reg_q_a, exp_a);
        check("rst_reg_q_b", reg_q_b, exp_b);
        presetn = 1'b1;
        @(negedge pclk);

        // Full-word write and read-back, zero wait states
        apb_xfer(0, 1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, rdat, err, nw);
        exp_a[32 +: 32] = 32'hDEAD_BEEF;
        check("wr04_waits", nw, 0);
        check("wr04_err", err, 0);
        check("wr04_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b000, 0, rdat, err, nw);
        check("rd04_waits", nw, 0);
        check("rd04_data", rdat, 32'hDEAD_BEEF);
        check("rd04_err", err, 0);

        // Byte strobes 0b0101 onto a zero register
        apb_xfer(0, 1, 32'h08, 32'h1122_3344, 4'h5, 3'b000, 0, rdat, err, nw);
        exp_a[64 +: 32] = 32'h0022_0044;
        apb_xfer(0, 0, 32'h08, 32'h0, 4'hF, 3'b000, 0, rdat, err, nw);
        check("strb_rd", rdat, 32'h0022_0044);
        check("strb_reg_q", reg_q_a, exp_a);

        // Address errors: out of range write, misaligned reads
        apb_xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, rdat, err, nw);
        check("oor_wr_err", err, 1);
        check("oor_wr_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 0, 32'h02, 32'h0, 4'h0, 3'b000, 0, rdat, err, nw);
        check("mis02_err", err, 1);
        check("mis02_data", rdat, 0);
        apb_xfer(0, 0, 32'h06, 32'h0, 4'h0, 3'b000, 0, rdat, err, nw);
        check("mis06_err", err, 1);
        check("mis06_data", rdat, 0);
        apb_xfer(0, 1, 32'h05, 32'h1234_5678, 4'hF, 3'b000, 0, rdat, err, nw);
        check("mis05_wr_err", err, 1);
        check("mis05_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 0, 32'h1C, 32'h0, 4'h0, 3'b000, 0, rdat, err, nw);
        check("last_reg_err", err, 0);
        check("last_reg_data", rdat, 0);

`ifdef APB_REG_PROT_EN
        // Privileged register 0: unprivileged write rejected, then privileged
        // write and read issued back-to-back with no idle cycle.
        apb_xfer(0, 1, 32'h00, 32'h55AA_55AA, 4'hF, 3'b000, 1, rdat, err, nw);
        check("prot_denied_err", err, 1);
        check("prot_denied_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 1, 32'h00, 32'h55AA_55AA, 4'hF, 3'b001, 1, rdat, err, nw);
        exp_a[0 +: 32] = 32'h55AA_55AA;
        check("prot_ok_err", err, 0);
        check("prot_ok_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 0, rdat, err, nw);
        check("prot_b2b_rd", rdat, 32'h55AA_55AA);
        check("prot_b2b_err", err, 0);
`else
        // Without the privilege check, pprot is ignored; also exercises back-to-back.
        apb_xfer(0, 1, 32'h00, 32'h55AA_55AA, 4'hF, 3'b000, 1, rdat, err, nw);
        exp_a[0 +: 32] = 32'h55AA_55AA;
        check("noprot_wr_err", err, 0);
        check("noprot_reg_q", reg_q_a, exp_a);
        apb_xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b000, 0, rdat, err, nw);
        check("noprot_b2b_rd", rdat, 32'h55AA_55AA);
`endif

        // Three wait states
        apb_xfer(1, 0, 32'h00, 32'h0, 4'h0, 3'b001, 0, rdat, err, nw);
        check("ws3_rd_waits", nw, 3);
        check("ws3_rd_data", rdat, 32'hA5A5_0000);
        check("ws3_rd_err", err, 0);
        apb_xfer(1, 1, 32'h0C, 32'h1234_5678, 4'hF, 3'b001, 0, rdat, err, nw);
        exp_b[96 +: 32] = 32'h1234_5678;
        check("ws3_wr_waits", nw, 3);
        check("ws3_wr_reg_q", reg_q_b, exp_b);

        // Abort: drop psel after one waited access cycle
        cur_b   = 1'b1;
        psel_b  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hCAFE_F00D;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("abort_mid_pready", pready_b, 0);
        psel_b  = 1'b0;
        penable = 1'b0;
        repeat (5) @(negedge pclk);
        check("abort_pready", pready_b, 0);
        check("abort_reg_q", reg_q_b, exp_b);
        apb_xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b001, 0, rdat, err, nw);
        check("abort_rd_waits", nw, 3);
        check("abort_rd_data", rdat, 32'hA5A5_0000);

        // Asynchronous reset while pready is high in the access phase
        cur_b   = 1'b0;
        psel_a  = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h0BAD_0BAD;
        @(negedge pclk);
        penable = 1'b1;
        check("pre_rst_pready", pready_a, 1);
        #1;
        presetn = 1'b0;
        #1;
        check("mid_rst_pready", pready_a, 0);
        check("mid_rst_reg_q_a", reg_q_a, 256'h0);
        check("mid_rst_reg_q_b", reg_q_b, {8{32'hA5A5_0000}});
        psel_a  = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        apb_xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001, 0, rdat, err, nw);
        check("post_rst_rd", rdat, 0);
        check("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- Parametrised APB4 completer: terminates the bus defined by the team's APB interface and implements a bank of NUM_REGS read/write registers.
- Successor to the fixed 32-bit, zero-wait APB link. Adds configurable address and data width, byte strobes, programmable wait states, and PSLVERR on illegal accesses.
- Register contents are exported flat to downstream logic.

Parameters:
- ADDR_W, 32, width of paddr.
- DATA_W, 32, width of pwdata/prdata; legal values 8, 16, 32, 64.
- NUM_REGS, 8, number of registers; legal range 1..256.
- WAIT_STATES, 0, wait cycles (pready low) in each access phase; legal range 0..15.
- RESET_VAL, 0, reset value of every register (DATA_W bits).
- PRIV_MASK, 0, bit i set marks register i as privileged (used only under the optional feature).

Ports:
- pclk, input, 1, APB clock; all logic on its rising edge.
- presetn, input, 1, asynchronous active-low reset.
- psel, input, 1, slave select.
- penable, input, 1, access phase.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, ADDR_W, byte address.
- pwdata, input, DATA_W, write data.
- pstrb, input, DATA_W/8, write byte strobes.
- pprot, input, 3, protection attributes; bit 0 = privileged.
- prdata, output, DATA_W, read data.
- pready, output, 1, transfer complete.
- pslverr, output, 1, transfer error; qualified by pready.
- reg_q, output, NUM_REGS*DATA_W, register contents; register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (presetn low, asynchronous):
  - State goes to IDLE.
  - pready=0, pslverr=0, prdata=0.
  - Wait counter = 0.
  - Every register = RESET_VAL.
- All outputs are registered.
- Decode:
  - OFS = log2(DATA_W/8).
  - idx = paddr >> OFS.
  - Illegal access = paddr[OFS-1:0] != 0 (when OFS > 0), or idx >= NUM_REGS.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - On an edge sampling psel=1, penable=0 (setup phase): capture pwrite, idx, pwdata, pstrb, error flag and pprot, then go to ACCESS.
  - Load the counter with WAIT_STATES.
  - If WAIT_STATES == 0, assert pready on the same edge, so pready is high in the first access cycle.
- ACCESS:
  - Each edge with psel=1, penable=1 and pready=0 decrements the counter.
  - When the counter reaches 1, assert pready on that edge.
  - Result: exactly WAIT_STATES access cycles with pready low, then one cycle with pready high.
- pready assertion edge:
  - pslverr = error flag.
  - Read, no error: prdata = register[idx].
  - Read with error: prdata = 0.
- Completion edge (psel=1, penable=1, pready=1 sampled):
  - Write without error: commit byte lane b from captured pwdata wherever pstrb[b]=1; other lanes unchanged.
  - Write with error: no register change.
  - Go to COMPLETE.
- COMPLETE (one cycle):
  - pready, pslverr and prdata return to 0.
  - Go to IDLE.
  - A setup phase sampled in this cycle is accepted as in IDLE, which allows back-to-back transfers.
- Abort: psel sampled 0 while in ACCESS → go to IDLE, no write, outputs cleared.
- penable sampled 0 with psel=1 while in ACCESS is treated as a new setup: restart capture and reload the counter.
- Reads never have side effects. pstrb is ignored on reads.
- reg_q reflects a write on the cycle after the completion edge.
- Reset asserted mid-transfer: the transfer is dropped and all state, outputs and registers are reset immediately.

Optional Feature:
- Macro: APB_REG_PROT_EN.
- Defined:
  - An access to register i with PRIV_MASK[i]=1 and captured pprot[0]=0 is an error: pslverr=1, write suppressed, prdata=0.
  - This is combined (OR) with the address error.
- Undefined: pprot is ignored entirely and PRIV_MASK has no effect.

Decomposition:
- Package apb_reg_pkg contains:
  - State enum (IDLE, ACCESS, COMPLETE).
  - Maximum wait-states constant (15).
  - Function computing OFS from DATA_W.
  - Pprot bit-index constants.
- One natural sub-module, apb_reg_bank:
  - Holds the register array, byte-strobe write logic, read mux and reg_q flattening.
  - Inputs: write enable, idx, data, strobe, read idx.
  - The top module holds the FSM, wait counter and error decode.

Test Plan:
1. Default params: write 0xDEADBEEF to 0x04 with pstrb=0xF, then read 0x04 → pready high in the first access cycle, prdata=0xDEADBEEF, pslverr=0, reg_q[63:32]=0xDEADBEEF.
2. WAIT_STATES=3: read 0x00 → exactly 3 access cycles with pready=0, then pready=1; prdata=RESET_VAL.
3. Byte strobes: write 0x11223344 with pstrb=0x5 to a register holding 0 → reads back 0x00220044.
4. Errors: write to 0x20 (idx 8 with NUM_REGS=8) and read 0x02 (misaligned) → pslverr=1 with pready, no register changes, prdata=0.
5. Abort and reset: drop psel mid-ACCESS with WAIT_STATES=2 → no write, FSM back to IDLE. Assert presetn=0 mid-access → pready=0 and all registers = RESET_VAL immediately.
6. APB_REG_PROT_EN with PRIV_MASK=0x1: write to 0x00 with pprot=0 → pslverr=1, no write. Same write with pprot=1 → succeeds. Back-to-back with no idle gap → both transfers complete.
